remote_paddle_ctl: RTL and testbench

- Consumes bytes from the UART receiver and decodes 3-byte command packets from a remote player.
- Drives the second paddle's btn_up/btn_down levels and a one-cycle serve pulse; sits between the UART receiver and the paddle/ball control logic.
- A link watchdog releases the paddle if packets stop arriving; malformed packets are counted.

---
 rtl/pong_uart_pkg.sv | 23 ++
 rtl/down_timer.sv | 33 +++
 rtl/remote_paddle_ctl.sv | 167 ++++++++++++++++
 tb/tb_remote_paddle_ctl.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pong_uart_pkg.sv
// Shared types and constants for the remote paddle UART command path.
package pong_uart_pkg;

  typedef enum logic [1:0] {
    CMD_STOP  = 2'b00,
    CMD_UP    = 2'b01,
    CMD_DOWN  = 2'b10,
    CMD_SERVE = 2'b11
  } cmd_t;

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    GOT_SYNC = 2'b01,
    GOT_CMD  = 2'b10
  } state_t;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

  function automatic logic [7:0] pkt_chk(input logic [7:0] sync_b, input logic [7:0] cmd_b);
    return sync_b ^ cmd_b;
  endfunction

endpackage

// File: rtl/down_timer.sv
// Loadable down-counter; expired pulses in the cycle whose edge takes the count to 0.
// A load or clear in that cycle suppresses the expiry.
module down_timer #(
  parameter int WIDTH = 8,
  parameter int LOAD  = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic clear,
  output logic expired
);

  localparam logic [WIDTH-1:0] LP_LOAD = WIDTH'(LOAD);
  localparam logic [WIDTH-1:0] LP_ONE  = WIDTH'(1);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (load) begin
      r_count <= LP_LOAD;
    end else if (r_count != '0) begin
      r_count <= r_count - LP_ONE;
    end
  end

  assign expired = (r_count == LP_ONE) && !load && !clear;

endmodule

// File: rtl/remote_paddle_ctl.sv
// Decodes SYNC/CMD/CHK packets from the UART into paddle levels and a serve pulse.
// Outputs update one edge after the accepted CHK byte; rx has no backpressure.
module remote_paddle_ctl
  import pong_uart_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE    = SYNC_BYTE_DEFAULT,
  parameter int         BYTE_TIMEOUT = 650_000,
  parameter int         HOLD_CYCLES  = 6_500_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       btn_up,
  output logic       btn_down,
  output logic       serve,
  output logic       link_active,
  output logic [7:0] err_count
);

  localparam int BT_W = $clog2(BYTE_TIMEOUT + 1);
  localparam int HT_W = $clog2(HOLD_CYCLES + 1);

  state_t     r_state;
  state_t     w_next;
  logic [7:0] r_cmd;
  logic       r_up;
  logic       r_down;
  logic       r_link;
  logic       r_serve;
  logic [7:0] r_err;

  logic w_is_sync;
  logic w_cmd_bad;
  logic w_chk_ok;
  logic w_accept;
  logic w_latch;
  logic w_error;
  logic w_byte_exp;
  logic w_hold_exp;
  logic w_hold_load;
  logic w_hold_clear;
  cmd_t w_acc_cmd;

  assign w_is_sync = (rx_data == SYNC_BYTE);
  assign w_cmd_bad = (rx_data[7:2] != 6'd0);
  assign w_chk_ok  = (rx_data == pkt_chk(SYNC_BYTE, r_cmd));
  assign w_acc_cmd = cmd_t'(r_cmd[1:0]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (rx_valid && w_is_sync) w_next = GOT_SYNC;
      end
      GOT_SYNC: begin
        if (rx_valid) begin
          if (w_is_sync)      w_next = GOT_SYNC;
          else if (w_cmd_bad) w_next = IDLE;
          else                w_next = GOT_CMD;
        end else if (w_byte_exp) begin
          w_next = IDLE;
        end
      end
      GOT_CMD: begin
        if (rx_valid) begin
          w_next = (w_is_sync && !w_chk_ok) ? GOT_SYNC : IDLE;
        end else if (w_byte_exp) begin
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    w_accept = 1'b0;
    w_latch  = 1'b0;
    w_error  = 1'b0;
    case (r_state)
      GOT_SYNC: begin
        if (rx_valid && !w_is_sync) begin
          w_latch = !w_cmd_bad;
          w_error = w_cmd_bad;
        end else if (!rx_valid && w_byte_exp) begin
          w_error = 1'b1;
        end
      end
      GOT_CMD: begin
        if (rx_valid) begin
          w_accept = w_chk_ok;
          w_error  = !w_chk_ok;
        end else if (w_byte_exp) begin
          w_error = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Byte timer only matters mid-packet; idling in IDLE keeps it parked at zero.
  down_timer #(.WIDTH(BT_W), .LOAD(BYTE_TIMEOUT)) u_byte_timer (
    .clk    (clk),
    .rst    (rst),
    .load   (rx_valid),
    .clear  ((r_state == IDLE) && !rx_valid),
    .expired(w_byte_exp)
  );

  assign w_hold_load  = w_accept && ((w_acc_cmd == CMD_UP) || (w_acc_cmd == CMD_DOWN));
  assign w_hold_clear = w_accept && (w_acc_cmd == CMD_STOP);

  down_timer #(.WIDTH(HT_W), .LOAD(HOLD_CYCLES)) u_hold_timer (
    .clk    (clk),
    .rst    (rst),
    .load   (w_hold_load),
    .clear  (w_hold_clear),
    .expired(w_hold_exp)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cmd <= 8'd0;
    end else if (w_latch) begin
      r_cmd <= rx_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_up    <= 1'b0;
      r_down  <= 1'b0;
      r_link  <= 1'b0;
      r_serve <= 1'b0;
      r_err   <= 8'd0;
    end else begin
      r_serve <= w_accept && (w_acc_cmd == CMD_SERVE);
      if (w_hold_load) begin
        r_up   <= (w_acc_cmd == CMD_UP);
        r_down <= (w_acc_cmd == CMD_DOWN);
        r_link <= 1'b1;
      end else if (w_hold_clear || w_hold_exp) begin
        r_up   <= 1'b0;
        r_down <= 1'b0;
        r_link <= 1'b0;
      end
      if (w_error && (r_err != 8'hFF)) begin
        r_err <= r_err + 8'd1;
      end
    end
  end

  assign btn_up      = r_up;
  assign btn_down    = r_down;
  assign link_active = r_link;
  assign serve       = r_serve;
  assign err_count   = r_err;

endmodule

// File: tb/tb_remote_paddle_ctl.sv
// Bench for remote_paddle_ctl: directed packets then random traffic against a queue-based model.
module tb_remote_paddle_ctl;

  localparam logic [7:0] SYNC = 8'hA5;
  localparam int         BT   = 50;
  localparam int         HOLD = 100;

  logic       clk;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       btn_up;
  logic       btn_down;
  logic       serve;
  logic       link_active;
  logic [7:0] err_count;

  int n_tests;
  int n_fail;

  remote_paddle_ctl #(
    .SYNC_BYTE   (SYNC),
    .BYTE_TIMEOUT(BT),
    .HOLD_CYCLES (HOLD)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .btn_up     (btn_up),
    .btn_down   (btn_down),
    .serve      (serve),
    .link_active(link_active),
    .err_count  (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: pending packet bytes, time of last byte, hold deadline.
  logic [7:0] pkt[$];
  int         n_cyc;
  int         last_byte;
  int         deadline;
  logic       m_up;
  logic       m_down;
  logic       m_link;
  logic       m_serve;
  int         m_err;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, n_cyc, got, exp);
    end
  endtask

  function automatic void model_reset();
    pkt.delete();
    last_byte = 0;
    deadline  = 0;
    m_up      = 1'b0;
    m_down    = 1'b0;
    m_link    = 1'b0;
    m_serve   = 1'b0;
    m_err     = 0;
  endfunction

  function automatic void model_err();
    if (m_err < 255) m_err++;
  endfunction

  function automatic void model_step(input logic v, input logic [7:0] d);
    logic       acc;
    logic [7:0] c;
    acc     = 1'b0;
    c       = 8'd0;
    m_serve = 1'b0;
    if (v) begin
      last_byte = n_cyc;
      if (pkt.size() == 0) begin
        if (d == SYNC) pkt.push_back(d);
      end else if (pkt.size() == 1) begin
        if (d != SYNC) begin
          if (d > 8'd3) begin
            model_err();
            pkt.delete();
          end else begin
            pkt.push_back(d);
          end
        end
      end else begin
        if (d == (SYNC ^ pkt[1])) begin
          acc = 1'b1;
          c   = pkt[1];
          pkt.delete();
        end else begin
          model_err();
          pkt.delete();
          if (d == SYNC) pkt.push_back(d);
        end
      end
    end else if ((pkt.size() != 0) && (n_cyc - last_byte == BT)) begin
      model_err();
      pkt.delete();
    end
    if (acc && (c == 8'd1 || c == 8'd2)) begin
      m_up     = (c == 8'd1);
      m_down   = (c == 8'd2);
      m_link   = 1'b1;
      deadline = n_cyc + HOLD;
    end else if (acc && c == 8'd0) begin
      m_up   = 1'b0;
      m_down = 1'b0;
      m_link = 1'b0;
    end else if (m_link && n_cyc == deadline) begin
      m_up   = 1'b0;
      m_down = 1'b0;
      m_link = 1'b0;
    end
    if (acc && c == 8'd3) m_serve = 1'b1;
  endfunction

  task automatic compare_all();
    check_eq("btn_up", btn_up, m_up);
    check_eq("btn_down", btn_down, m_down);
    check_eq("serve", serve, m_serve);
    check_eq("link_active", link_active, m_link);
    check_eq("err_count", err_count, m_err);
    check_eq("btn_excl", btn_up & btn_down, 0);
  endtask

  task automatic cycle(input logic v, input logic [7:0] d);
    rx_valid = v;
    rx_data  = d;
    @(posedge clk);
    n_cyc++;
    model_step(v, d);
    #1;
    compare_all();
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    cycle(1'b1, b);
    repeat (gap) cycle(1'b0, 8'h00);
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(1'b0, 8'h00);
  endtask

  task automatic do_reset();
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    rst      = 1'b1;
    #1;
    model_reset();
    compare_all();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    int         cnt;
    int         mode;
    int         gap;
    int         mid_gap;
    logic [7:0] b1;
    logic [7:0] b2;

    n_tests  = 0;
    n_fail   = 0;
    n_cyc    = 0;
    rst      = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    model_reset();
    #2;
    compare_all();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // 1: UP packet
    send_byte(SYNC, 0);
    send_byte(8'h01, 0);
    cycle(1'b1, 8'hA4);
    check_eq("t1_up", btn_up, 1);
    check_eq("t1_link", link_active, 1);
    check_eq("t1_err", err_count, 0);
    idle(3);

    // 2: DOWN packet, hold must last exactly HOLD cycles
    send_byte(SYNC, 1);
    send_byte(8'h02, 1);
    cnt = 0;
    cycle(1'b1, 8'hA7);
    if (btn_down) cnt++;
    repeat (150) begin
      cycle(1'b0, 8'h00);
      if (btn_down) cnt++;
    end
    check_eq("t2_down_len", cnt, HOLD);
    check_eq("t2_link_off", link_active, 0);

    // 3: SERVE is a single-cycle pulse
    send_byte(SYNC, 0);
    send_byte(8'h03, 0);
    cnt = 0;
    cycle(1'b1, 8'hA6);
    if (serve) cnt++;
    repeat (10) begin
      cycle(1'b0, 8'h00);
      if (serve) cnt++;
    end
    check_eq("t3_serve_cnt", cnt, 1);

    // 4: bad checksum, then resync into a STOP
    send_byte(SYNC, 0);
    send_byte(8'h01, 0);
    send_byte(8'hFF, 2);
    check_eq("t4_err1", err_count, 1);
    check_eq("t4_up_idle", btn_up, 0);
    send_byte(SYNC, 0);
    send_byte(SYNC, 0);
    send_byte(8'h00, 0);
    send_byte(SYNC, 2);
    check_eq("t4_err_keep", err_count, 1);

    // 5: inter-byte timeout, trailing CMD byte ignored
    send_byte(SYNC, 60);
    check_eq("t5_err2", err_count, 2);
    send_byte(8'h01, 3);
    check_eq("t5_ignored", err_count, 2);

    // 6: saturation, then reset mid-packet
    repeat (300) begin
      send_byte(SYNC, 0);
      send_byte(8'h01, 0);
      send_byte(8'h00, 0);
    end
    check_eq("t6_sat", err_count, 255);
    send_byte(SYNC, 0);
    send_byte(8'h01, 0);
    do_reset();
    send_byte(8'hA4, 3);
    check_eq("t6_after_rst_up", btn_up, 0);
    check_eq("t6_after_rst_err", err_count, 0);

    // Random traffic with corruptions and gaps around the timeout boundary
    for (int p = 0; p < 300; p++) begin
      mode    = $urandom_range(0, 9);
      gap     = $urandom_range(0, 5);
      mid_gap = (mode == 4) ? $urandom_range(BT - 3, BT + 3) : gap;
      b1      = 8'($urandom_range(0, 3));
      if (mode == 1) b1 = 8'($urandom_range(4, 255));
      b2 = SYNC ^ b1;
      if (mode == 0) b2 = 8'($urandom_range(0, 255));
      if (mode == 2) send_byte(8'($urandom_range(0, 255)), gap);
      send_byte(SYNC, gap);
      if (mode == 3) send_byte(SYNC, gap);
      send_byte(b1, mid_gap);
      send_byte(b2, gap);
      if ($urandom_range(0, 9) == 0) idle($urandom_range(HOLD - 20, HOLD + 20));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
